// File: rtl/afifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the arbiter and the async FIFO write port.
// The arbiter takes the master modport and the producer/FIFO side takes the slave modport.
interface afifo_wr_arbiter_if #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       grant;
    logic                  wr_full;
    logic [DSIZE-1:0]      wr_data;
    logic                  wr_inc;
    logic                  busy;
    logic [IDW-1:0]        owner_id;

    modport master (
        input  req, req_data, wr_full,
        output grant, wr_data, wr_inc, busy, owner_id
    );

    modport slave (
        output req, req_data, wr_full,
        input  grant, wr_data, wr_inc, busy, owner_id
    );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, bounded-burst arbiter sharing one async FIFO write port among NREQ producers.
// Zero-latency write in the grant cycle; wr_full stalls the owner without ending its tenure.
module afifo_wr_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic               wr_clk,
    input  logic               wr_rst,
    afifo_wr_arbiter_if.master bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BCW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rr_ptr;
    logic [BCW-1:0] burst_cnt;

    logic [IDW-1:0] next_owner;
    logic [IDW-1:0] scan_ptr;
    logic           found;
    logic           xfer;
    logic           last_beat;

    // Explicit wrap so non-power-of-two NREQ never lands on an unused index.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        return (v == IDW'(NREQ - 1)) ? '0 : v + IDW'(1);
    endfunction

    always_comb begin
        next_owner = rr_ptr;
        scan_ptr   = rr_ptr;
        found      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req[scan_ptr]) begin
                next_owner = scan_ptr;
                found      = 1'b1;
            end
            scan_ptr = wrap_inc(scan_ptr);
        end
    end

    assign xfer      = (state == GRANT) && bus.req[owner] && !bus.wr_full && !wr_rst;
    assign last_beat = (burst_cnt == BCW'(MAX_BURST - 1));

    assign bus.wr_inc   = xfer;
    assign bus.grant    = xfer ? (ONE_HOT0 << owner) : '0;
    assign bus.wr_data  = xfer ? bus.req_data[int'(owner)*DSIZE +: DSIZE] : '0;
    assign bus.busy     = (state == GRANT);
    assign bus.owner_id = owner;

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= next_owner;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.req[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= wrap_inc(owner);
                    end else if (!bus.wr_full) begin
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= wrap_inc(owner);
                        end else begin
                            burst_cnt <= burst_cnt + BCW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter: reset, single requester, fairness, full stall,
// early release and reset mid-burst, with per-cycle expected grant/busy/data/owner tables.
module tb_afifo_wr_arbiter;
    localparam int DSIZE     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;

    logic wr_clk = 1'b0;
    logic wr_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [NREQ-1:0] last_grant;

    afifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

    afifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus.master)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge wr_clk) begin
        chk("inv_inc_grant", 32'(bus.wr_inc), 32'(|bus.grant));
        chk("inv_no_overflow", 32'(bus.wr_inc & bus.wr_full), 32'd0);
    end

    task automatic next_cyc();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic set_default_data();
        for (int i = 0; i < NREQ; i++) bus.req_data[i*DSIZE +: DSIZE] = 8'hA0 + 8'(i);
    endtask

    task automatic do_reset();
        wr_rst      = 1'b1;
        bus.req     = '0;
        bus.wr_full = 1'b0;
        set_default_data();
        next_cyc();
        wr_rst = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] r, input logic f,
                           input logic [3:0] eg, input logic eb, input logic [7:0] ed,
                           input logic [1:0] eo);
        bus.req     = r;
        bus.wr_full = f;
        @(negedge wr_clk);
        last_grant = bus.grant;
        chk($sformatf("%s_grant", tag), 32'(bus.grant), 32'(eg));
        chk($sformatf("%s_inc", tag), 32'(bus.wr_inc), 32'(eg != 4'b0));
        chk($sformatf("%s_busy", tag), 32'(bus.busy), 32'(eb));
        chk($sformatf("%s_data", tag), 32'(bus.wr_data), 32'(ed));
        chk($sformatf("%s_owner", tag), 32'(bus.owner_id), 32'(eo));
        next_cyc();
    endtask

    logic [3:0] s_g [10] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
    logic       s_b [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] s_d [10] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15, 8'h00, 8'h00};
    logic [1:0] s_o [10] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};

    initial begin
        int writes;
        int sent;
        int idx;
        logic [3:0] eg;

        // Reset held two cycles with every requester asking.
        wr_rst      = 1'b1;
        bus.req     = 4'b1111;
        bus.wr_full = 1'b0;
        set_default_data();
        for (int c = 0; c < 2; c++) begin
            @(negedge wr_clk);
            chk($sformatf("rst%0d_grant", c), 32'(bus.grant), 32'd0);
            chk($sformatf("rst%0d_inc", c), 32'(bus.wr_inc), 32'd0);
            chk($sformatf("rst%0d_data", c), 32'(bus.wr_data), 32'd0);
            chk($sformatf("rst%0d_busy", c), 32'(bus.busy), 32'd0);
            chk($sformatf("rst%0d_owner", c), 32'(bus.owner_id), 32'd0);
            next_cyc();
        end
        wr_rst = 1'b0;

        // Fairness: four-word tenures, one bubble each, owners 0,1,2,3,0.
        writes = 0;
        for (int c = 0; c < 22; c++) begin
            idx = (c / 5) % 4;
            eg  = (c % 5 == 0) ? 4'b0 : (4'b1 << idx);
            run_vec($sformatf("fair%0d", c), 4'b1111, 1'b0, eg, (c % 5 != 0),
                    (c % 5 == 0) ? 8'h00 : 8'hA0 + 8'(idx),
                    (c == 0) ? 2'd0 : 2'((c - 1) / 5 % 4));
            if (c < 20 && last_grant != 4'b0) writes++;
        end
        chk("fair_writes_20cyc", 32'(writes), 32'd16);

        // Single requester streams 0x10..0x15: burst of 4, bubble, burst of 2.
        do_reset();
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            bus.req_data[1*DSIZE +: DSIZE] = 8'h10 + 8'(sent);
            run_vec($sformatf("single%0d", c), (sent < 6) ? 4'b0010 : 4'b0000, 1'b0,
                    s_g[c], s_b[c], s_d[c], s_o[c]);
            if (last_grant[1]) sent++;
        end
        chk("single_sent", 32'(sent), 32'd6);

        // Full stall: owner 2 keeps tenure through three full cycles; then rr_ptr=3.
        do_reset();
        run_vec("stall0", 4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
        run_vec("stall1", 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA2, 2'd2);
        run_vec("stall2", 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA2, 2'd2);
        run_vec("stall3", 4'b0100, 1'b1, 4'b0000, 1'b1, 8'h00, 2'd2);
        run_vec("stall4", 4'b0100, 1'b1, 4'b0000, 1'b1, 8'h00, 2'd2);
        run_vec("stall5", 4'b0100, 1'b1, 4'b0000, 1'b1, 8'h00, 2'd2);
        run_vec("stall6", 4'b1111, 1'b0, 4'b0100, 1'b1, 8'hA2, 2'd2);
        run_vec("stall7", 4'b1111, 1'b0, 4'b0100, 1'b1, 8'hA2, 2'd2);
        run_vec("stall8", 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd2);
        run_vec("stall9", 4'b1111, 1'b0, 4'b1000, 1'b1, 8'hA3, 2'd3);

        // Early release: owner 0 drops after two writes, requester 1 takes the next tenure.
        do_reset();
        run_vec("early0", 4'b0011, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
        run_vec("early1", 4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0);
        run_vec("early2", 4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0);
        run_vec("early3", 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h00, 2'd0);
        run_vec("early4", 4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
        run_vec("early5", 4'b0010, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd1);

        // Reset mid-burst: owner 3 after one write; arbitration restarts at requester 0.
        do_reset();
        run_vec("mrst0", 4'b1000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
        run_vec("mrst1", 4'b1000, 1'b0, 4'b1000, 1'b1, 8'hA3, 2'd3);
        wr_rst  = 1'b1;
        bus.req = 4'b1000;
        @(negedge wr_clk);
        chk("mrst2_grant", 32'(bus.grant), 32'd0);
        chk("mrst2_inc", 32'(bus.wr_inc), 32'd0);
        chk("mrst2_data", 32'(bus.wr_data), 32'd0);
        next_cyc();
        wr_rst = 1'b0;
        run_vec("mrst3", 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
        run_vec("mrst4", 4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/afifo_wr_arbiter.md
Name: afifo_wr_arbiter

Overview:
- Write-side arbiter for the async FIFO.
- Shares the single FIFO write port (wr_data/wr_inc/wr_full) between NREQ requesters using round-robin, bounded bursts.
- Sits entirely in the write clock domain, between the producer blocks and the FIFO write interface.
- Holds wr_inc low whenever wr_full is high, so the FIFO never overflows.

Parameters:
DSIZE, 8, data word width; matches the FIFO DSIZE.
NREQ, 4, number of requesters; must be >= 2.
MAX_BURST, 4, maximum words granted to one owner per tenure; must be >= 1.

Ports:
wr_clk  input  1  write-domain clock; all state updates on rising edge.
wr_rst  input  1  synchronous, active-high reset.
req  input  NREQ  req[i] high = requester i has a word on its req_data slice.
req_data  input  NREQ*DSIZE  word for requester i at bits [i*DSIZE +: DSIZE].
grant  output  NREQ  one-hot; grant[i] high = requester i's word is written this cycle.
wr_full  input  1  FIFO full flag (write domain).
wr_data  output  DSIZE  FIFO write data.
wr_inc  output  1  FIFO write enable.
busy  output  1  high while in GRANT state.
owner_id  output  clog2(NREQ)  current/last owner index.

Behaviour:
- Registered state:
  - state: IDLE or GRANT.
  - owner: clog2(NREQ) bits.
  - rr_ptr: clog2(NREQ) bits.
  - burst_cnt: max(1, clog2(MAX_BURST)) bits.
- Reset (wr_rst high at an edge): state=IDLE, owner=0, rr_ptr=0, burst_cnt=0.
- During any cycle with wr_rst high: grant=0, wr_inc=0, wr_data=0 (combinational gate).
- An in-progress burst is abandoned on reset; no partial state survives.
- IDLE:
  - grant=0, wr_inc=0, wr_data=0, busy=0.
  - If any req bit is high: owner <= first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ; burst_cnt <= 0; state <= GRANT.
  - If no req bit is high: stay in IDLE.
- GRANT (busy=1):
  - xfer = req[owner] & ~wr_full.
  - wr_inc = xfer.
  - grant = xfer ? (1 << owner) : 0.
  - wr_data = xfer ? req_data[owner] : 0.
  - All three are combinational: the write happens in the same cycle the word is accepted (zero latency).
- GRANT transitions, in priority order:
  - 1. req[owner]=0: state <= IDLE, rr_ptr <= (owner+1) mod NREQ. This holds regardless of wr_full.
  - 2. xfer and burst_cnt == MAX_BURST-1: state <= IDLE, rr_ptr <= (owner+1) mod NREQ.
  - 3. xfer otherwise: burst_cnt <= burst_cnt+1, stay in GRANT.
  - 4. req[owner]=1 and wr_full=1: stall; burst_cnt and owner hold, stay in GRANT. Full never costs the owner its tenure.
- Each tenure costs one arbitration bubble (the IDLE cycle). Peak throughput = MAX_BURST/(MAX_BURST+1).
- Requesters must hold req and req_data stable until grant. A requester may drop req without a grant; this ends its tenure if it is the owner.
- Non-owner req changes during GRANT have no effect until the next IDLE.
- rr_ptr wraps from NREQ-1 to 0. NREQ that is not a power of two must wrap explicitly, not by truncation.
- owner_id = owner at all times; reads 0 after reset.
- Invariants: grant is one-hot or zero; wr_inc == |grant; wr_inc & wr_full is never 1.

Test Plan:
- Reset: wr_rst high 2 cycles with req=4'b1111, wr_full=0 -> grant=0, wr_inc=0, wr_data=0, busy=0, owner_id=0 during reset; first write after release comes from requester 0, one cycle after the IDLE arbitration cycle.
- Single requester: req[1] held, data 0x10..0x15 presented in order, MAX_BURST=4 -> bursts of 4 then 2 writes with one bubble between; FIFO receives 0x10..0x15 in order; grant=4'b0010 on every write.
- Fairness: req=4'b1111 held, wr_full=0 -> owner sequence 0,1,2,3,0; exactly 4 writes per tenure; 1 idle cycle between tenures; 16 writes in 20 cycles.
- Full stall: owner 2 mid-burst after 2 writes, wr_full high 3 cycles -> wr_inc=0, grant=0, busy=1 for 3 cycles; burst resumes with owner 2 for exactly 2 more writes, then rr_ptr=3.
- Early release: req=4'b0011, owner 0 drops req after 2 writes -> next cycle IDLE, following tenure owned by requester 1.
- Reset mid-burst: wr_rst high while owner 3 has done 1 write -> wr_inc=0 in the reset cycle; after release owner_id=0, and arbitration restarts from rr_ptr=0.
